// File: rtl/u400_arb_pkg.sv
// u400_arb_pkg: shared state type and sizing constants for the U400 SDRAM
// refresh scheduler / access arbiter.
package u400_arb_pkg;

  // Width of the postponed-refresh counter (holds 0..15).
  localparam int PEND_W = 4;

  // Width of the refresh interval down-counter (covers intervals up to 4095).
  localparam int IVL_W = 12;

  localparam int DEF_REFRESH_INTERVAL = 312;
  localparam int DEF_MAX_PENDING      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_REF  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/u400_refresh_timer.sv
// u400_refresh_timer: refresh interval down-counter, postponed-refresh
// counter, urgent compare and the optional lost-refresh flag.
// Optional feature macro: U400_REF_OVF_EN (builds the sticky overflow flag).
module u400_refresh_timer
  import u400_arb_pkg::*;
#(
  parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
  parameter int MAX_PENDING      = DEF_MAX_PENDING
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_en,
  input  logic              gnt_ref,
  output logic [PEND_W-1:0] pending,
  output logic              urgent,
  output logic              ovf
);

  localparam logic [IVL_W-1:0]  RELOAD   = IVL_W'(REFRESH_INTERVAL - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  logic [IVL_W-1:0]  ivl_q, ivl_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              urgent_q, urgent_d;
  logic              tick;

  // Interval counter: parked at the reload value until init is done, then
  // counts down and raises a tick on the cycle it reads zero.
  always_comb begin
    tick  = 1'b0;
    ivl_d = ivl_q;
    if (!tick_en) begin
      ivl_d = RELOAD;
    end else if (ivl_q == '0) begin
      tick  = 1'b1;
      ivl_d = RELOAD;
    end else begin
      ivl_d = ivl_q - IVL_W'(1);
    end
  end

  // Pending counter: tick adds, a refresh grant removes, both together cancel;
  // a tick at the ceiling is dropped. Urgent is registered alongside the count.
  always_comb begin
    pend_d = pend_q;
    if (tick && !gnt_ref && (pend_q != PEND_MAX)) begin
      pend_d = pend_q + PEND_W'(1);
    end else if (!tick && gnt_ref && (pend_q != '0)) begin
      pend_d = pend_q - PEND_W'(1);
    end
    urgent_d = (pend_d == PEND_MAX);
  end

  // Counter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ivl_q    <= RELOAD;
      pend_q   <= '0;
      urgent_q <= 1'b0;
    end else begin
      ivl_q    <= ivl_d;
      pend_q   <= pend_d;
      urgent_q <= urgent_d;
    end
  end

  assign pending = pend_q;
  assign urgent  = urgent_q;

`ifdef U400_REF_OVF_EN
  logic ovf_q, ovf_d;

  // A tick at the ceiling with no refresh being granted is a lost refresh.
  always_comb begin
    ovf_d = ovf_q | (tick && !gnt_ref && (pend_q == PEND_MAX));
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/u400_sdram_arbiter.sv
// u400_sdram_arbiter: grants the SDRAM command sequencer to either a decoded
// 68040 RAM-space transfer or an auto-refresh, one operation at a time.
// Optional feature macro: U400_REF_OVF_EN (sticky lost-refresh flag on REF_OVF).
//
// state | meaning
// IDLE  | sequencer free; choose urgent refresh > CPU > opportunistic refresh
// CPU   | CPU access in progress, wait for CYCLE_DONE
// REF   | auto-refresh in progress, wait for CYCLE_DONE
module u400_sdram_arbiter
  import u400_arb_pkg::*;
#(
  parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
  parameter int MAX_PENDING      = DEF_MAX_PENDING
) (
  input  logic              CLK40,
  input  logic              RESET,
  input  logic              INIT_DONE,
  input  logic              TS_RAM,
  input  logic              CYCLE_DONE,
  output logic              GNT_CPU,
  output logic              GNT_REF,
  output logic              CPU_WAIT,
  output logic              REF_URGENT,
  output logic [PEND_W-1:0] REF_PENDING,
  output logic              REF_OVF
);

  arb_state_e        state_q, state_d;
  logic              cpu_lat_q, cpu_lat_d;
  logic              gnt_cpu_q, gnt_cpu_d;
  logic              gnt_ref_q, gnt_ref_d;
  logic [PEND_W-1:0] ref_pending;
  logic              ref_urgent;
  logic              ref_ovf;

  u400_refresh_timer #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL),
    .MAX_PENDING      (MAX_PENDING)
  ) u_refresh_timer (
    .clk     (CLK40),
    .rst     (RESET),
    .tick_en (INIT_DONE),
    .gnt_ref (gnt_ref_q),
    .pending (ref_pending),
    .urgent  (ref_urgent),
    .ovf     (ref_ovf)
  );

  // Next-state and grant decision; grants are one-cycle registered pulses.
  always_comb begin
    state_d   = state_q;
    gnt_cpu_d = 1'b0;
    gnt_ref_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (INIT_DONE) begin
          if (ref_urgent) begin
            gnt_ref_d = 1'b1;
            state_d   = ST_REF;
          end else if (cpu_lat_q) begin
            gnt_cpu_d = 1'b1;
            state_d   = ST_CPU;
          end else if (ref_pending != '0) begin
            gnt_ref_d = 1'b1;
            state_d   = ST_REF;
          end
        end
      end
      ST_CPU, ST_REF: begin
        if (CYCLE_DONE) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // CPU request latch: captured only in IDLE with nothing held, dropped on grant.
  always_comb begin
    cpu_lat_d = cpu_lat_q;
    if (gnt_cpu_d) begin
      cpu_lat_d = 1'b0;
    end else if (TS_RAM && (state_q == ST_IDLE) && !cpu_lat_q) begin
      cpu_lat_d = 1'b1;
    end
  end

  // FSM, latch and grant registers.
  always_ff @(posedge CLK40 or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cpu_lat_q <= 1'b0;
      gnt_cpu_q <= 1'b0;
      gnt_ref_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpu_lat_q <= cpu_lat_d;
      gnt_cpu_q <= gnt_cpu_d;
      gnt_ref_q <= gnt_ref_d;
    end
  end

  assign GNT_CPU     = gnt_cpu_q;
  assign GNT_REF     = gnt_ref_q;
  assign CPU_WAIT    = cpu_lat_q;
  assign REF_URGENT  = ref_urgent;
  assign REF_PENDING = ref_pending;
  assign REF_OVF     = ref_ovf;

endmodule

// File: tb/tb_u400_sdram_arbiter.sv
// tb_u400_sdram_arbiter: directed scenarios with REFRESH_INTERVAL=16,
// MAX_PENDING=4. Edge E0 is the last edge before inputs are applied after a
// reset release; ticks then land on edges E16, E32, E48, ...
module tb_u400_sdram_arbiter;

  logic       CLK40 = 1'b0;
  logic       RESET = 1'b1;
  logic       INIT_DONE = 1'b0;
  logic       TS_RAM = 1'b0;
  logic       CYCLE_DONE = 1'b0;
  logic       GNT_CPU, GNT_REF, CPU_WAIT, REF_URGENT, REF_OVF;
  logic [3:0] REF_PENDING;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef U400_REF_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  always #5 CLK40 = ~CLK40;

  u400_sdram_arbiter #(
    .REFRESH_INTERVAL (16),
    .MAX_PENDING      (4)
  ) dut (
    .CLK40       (CLK40),
    .RESET       (RESET),
    .INIT_DONE   (INIT_DONE),
    .TS_RAM      (TS_RAM),
    .CYCLE_DONE  (CYCLE_DONE),
    .GNT_CPU     (GNT_CPU),
    .GNT_REF     (GNT_REF),
    .CPU_WAIT    (CPU_WAIT),
    .REF_URGENT  (REF_URGENT),
    .REF_PENDING (REF_PENDING),
    .REF_OVF     (REF_OVF)
  );

  task automatic step(input int n);
    repeat (n) @(posedge CLK40);
    #1;
  endtask

  task automatic do_reset(input logic init);
    RESET = 1'b1; INIT_DONE = 1'b0; TS_RAM = 1'b0; CYCLE_DONE = 1'b0;
    step(3);
    RESET = 1'b0; INIT_DONE = init;
  endtask

  // Pulse TS_RAM at E1 so the CPU is granted at E2 and holds the sequencer.
  task automatic enter_cpu();
    do_reset(1'b1);
    TS_RAM = 1'b1; step(1); TS_RAM = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    step(2);
    n_cmp++;
    if ({GNT_CPU, GNT_REF, CPU_WAIT, REF_URGENT, REF_PENDING, REF_OVF} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 000000000",
               {GNT_CPU, GNT_REF, CPU_WAIT, REF_URGENT, REF_PENDING, REF_OVF});
    end
  endtask

  task automatic test_init_hold();
    int grants;
    int nz;
    int lat;
    logic found;
    grants = 0; nz = 0; lat = 0; found = 1'b0;
    do_reset(1'b0);
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (GNT_CPU || GNT_REF) grants++;
      if (REF_PENDING != 4'd0) nz++;
    end
    n_cmp++;
    if (grants !== 0) begin
      n_bad++; $display("FAIL init_hold_grants: got %0d want 0", grants);
    end
    n_cmp++;
    if (nz !== 0) begin
      n_bad++; $display("FAIL init_hold_pending: nonzero cycles %0d want 0", nz);
    end
    INIT_DONE = 1'b1;
    for (int i = 1; i <= 40 && !found; i++) begin
      step(1);
      if (GNT_REF) begin found = 1'b1; lat = i; end
    end
    n_cmp++;
    if (!found || lat < 17 || lat > 18) begin
      n_bad++; $display("FAIL init_first_ref: found=%0d latency %0d want 17..18", found, lat);
    end
    n_cmp++;
    if (REF_PENDING !== 4'd1) begin
      n_bad++; $display("FAIL init_ref_pending: got %0d want 1", REF_PENDING);
    end
    CYCLE_DONE = 1'b1; step(1); CYCLE_DONE = 1'b0;
    n_cmp++;
    if (REF_PENDING !== 4'd0 || GNT_REF !== 1'b0) begin
      n_bad++; $display("FAIL init_drained: pending %0d gnt_ref %b want 0 0", REF_PENDING, GNT_REF);
    end
  endtask

  task automatic test_single_cpu();
    do_reset(1'b1);
    TS_RAM = 1'b1; step(1); TS_RAM = 1'b0;
    n_cmp++;
    if (CPU_WAIT !== 1'b1 || GNT_CPU !== 1'b0) begin
      n_bad++; $display("FAIL cpu_latch: wait %b gnt %b want 1 0", CPU_WAIT, GNT_CPU);
    end
    step(1);
    n_cmp++;
    if (GNT_CPU !== 1'b1 || CPU_WAIT !== 1'b0 || GNT_REF !== 1'b0) begin
      n_bad++; $display("FAIL cpu_grant: gnt_cpu %b wait %b gnt_ref %b want 1 0 0",
                        GNT_CPU, CPU_WAIT, GNT_REF);
    end
    TS_RAM = 1'b1; CYCLE_DONE = 1'b1; step(1); TS_RAM = 1'b0; CYCLE_DONE = 1'b0;
    n_cmp++;
    if (GNT_CPU !== 1'b0 || CPU_WAIT !== 1'b0) begin
      n_bad++; $display("FAIL cpu_ts_in_cpu_ignored: gnt %b wait %b want 0 0", GNT_CPU, CPU_WAIT);
    end
    step(1);
    n_cmp++;
    if (GNT_CPU !== 1'b0 || GNT_REF !== 1'b0) begin
      n_bad++; $display("FAIL cpu_no_regrant: gnt_cpu %b gnt_ref %b want 0 0", GNT_CPU, GNT_REF);
    end
  endtask

  task automatic test_urgent_priority();
    enter_cpu();
    n_cmp++;
    if (GNT_CPU !== 1'b1) begin
      n_bad++; $display("FAIL urg_cpu_grant: got %b want 1", GNT_CPU);
    end
    step(14);
    n_cmp++;
    if (REF_PENDING !== 4'd1) begin
      n_bad++; $display("FAIL urg_pending_e16: got %0d want 1", REF_PENDING);
    end
    step(16);
    n_cmp++;
    if (REF_PENDING !== 4'd2) begin
      n_bad++; $display("FAIL urg_pending_e32: got %0d want 2", REF_PENDING);
    end
    step(31);
    n_cmp++;
    if (REF_PENDING !== 4'd3 || REF_URGENT !== 1'b0) begin
      n_bad++; $display("FAIL urg_e63: pending %0d urgent %b want 3 0", REF_PENDING, REF_URGENT);
    end
    step(1);
    n_cmp++;
    if (REF_PENDING !== 4'd4 || REF_URGENT !== 1'b1 || GNT_REF !== 1'b0) begin
      n_bad++; $display("FAIL urg_e64: pending %0d urgent %b gnt_ref %b want 4 1 0",
                        REF_PENDING, REF_URGENT, GNT_REF);
    end
    CYCLE_DONE = 1'b1; step(1); CYCLE_DONE = 1'b0;
    TS_RAM = 1'b1; step(1); TS_RAM = 1'b0;
    n_cmp++;
    if (GNT_REF !== 1'b1 || GNT_CPU !== 1'b0 || CPU_WAIT !== 1'b1) begin
      n_bad++; $display("FAIL urg_ref_first: gnt_ref %b gnt_cpu %b wait %b want 1 0 1",
                        GNT_REF, GNT_CPU, CPU_WAIT);
    end
    step(1);
    n_cmp++;
    if (REF_PENDING !== 4'd3 || REF_URGENT !== 1'b0) begin
      n_bad++; $display("FAIL urg_after_ref: pending %0d urgent %b want 3 0", REF_PENDING, REF_URGENT);
    end
    CYCLE_DONE = 1'b1; step(1); CYCLE_DONE = 1'b0;
    step(1);
    n_cmp++;
    if (GNT_CPU !== 1'b1 || GNT_REF !== 1'b0 || CPU_WAIT !== 1'b0) begin
      n_bad++; $display("FAIL urg_cpu_second: gnt_cpu %b gnt_ref %b wait %b want 1 0 0",
                        GNT_CPU, GNT_REF, CPU_WAIT);
    end
  endtask

  task automatic test_tick_with_grant();
    enter_cpu();
    step(43);
    n_cmp++;
    if (REF_PENDING !== 4'd2) begin
      n_bad++; $display("FAIL same_pre: pending %0d want 2", REF_PENDING);
    end
    CYCLE_DONE = 1'b1; step(1); CYCLE_DONE = 1'b0;
    step(1);
    n_cmp++;
    if (GNT_REF !== 1'b1 || REF_PENDING !== 4'd2) begin
      n_bad++; $display("FAIL same_grant: gnt_ref %b pending %0d want 1 2", GNT_REF, REF_PENDING);
    end
    step(1);
    n_cmp++;
    if (REF_PENDING !== 4'd2) begin
      n_bad++; $display("FAIL same_cycle_pending: got %0d want 2", REF_PENDING);
    end
    step(1);
    n_cmp++;
    if (REF_PENDING !== 4'd2 || GNT_REF !== 1'b0) begin
      n_bad++; $display("FAIL same_hold: pending %0d gnt_ref %b want 2 0", REF_PENDING, GNT_REF);
    end
  endtask

  task automatic test_overflow();
    enter_cpu();
    step(77);
    n_cmp++;
    if (REF_OVF !== 1'b0 || REF_PENDING !== 4'd4) begin
      n_bad++; $display("FAIL ovf_e79: ovf %b pending %0d want 0 4", REF_OVF, REF_PENDING);
    end
    step(1);
    n_cmp++;
    if (REF_OVF !== OVF_EXP || REF_PENDING !== 4'd4 || REF_URGENT !== 1'b1) begin
      n_bad++; $display("FAIL ovf_e80: ovf %b pending %0d urgent %b want %b 4 1",
                        REF_OVF, REF_PENDING, REF_URGENT, OVF_EXP);
    end
    CYCLE_DONE = 1'b1; step(1); CYCLE_DONE = 1'b0;
    step(4);
    n_cmp++;
    if (REF_OVF !== OVF_EXP || REF_PENDING !== 4'd3) begin
      n_bad++; $display("FAIL ovf_sticky: ovf %b pending %0d want %b 3", REF_OVF, REF_PENDING, OVF_EXP);
    end
  endtask

  task automatic test_reset_mid_ref();
    int early;
    early = 0;
    enter_cpu();
    step(62);
    CYCLE_DONE = 1'b1; step(1); CYCLE_DONE = 1'b0;
    step(2);
    n_cmp++;
    if (REF_PENDING !== 4'd3 || GNT_REF !== 1'b0) begin
      n_bad++; $display("FAIL rst_setup: pending %0d gnt_ref %b want 3 0", REF_PENDING, GNT_REF);
    end
    RESET = 1'b1;
    #1;
    n_cmp++;
    if ({GNT_CPU, GNT_REF, CPU_WAIT, REF_URGENT, REF_PENDING, REF_OVF} !== 9'b0) begin
      n_bad++; $display("FAIL rst_async_outputs: got %b want 000000000",
                        {GNT_CPU, GNT_REF, CPU_WAIT, REF_URGENT, REF_PENDING, REF_OVF});
    end
    step(2);
    RESET = 1'b0;
    TS_RAM = 1'b1; step(1); TS_RAM = 1'b0;
    step(1);
    n_cmp++;
    if (GNT_CPU !== 1'b1) begin
      n_bad++; $display("FAIL rst_idle_cpu_grant: got %b want 1", GNT_CPU);
    end
    CYCLE_DONE = 1'b1; step(1); CYCLE_DONE = 1'b0;
    for (int i = 4; i <= 16; i++) begin
      step(1);
      if (GNT_REF) early++;
    end
    n_cmp++;
    if (early !== 0 || REF_PENDING !== 4'd1) begin
      n_bad++; $display("FAIL rst_new_interval: early refs %0d pending %0d want 0 1", early, REF_PENDING);
    end
    step(1);
    n_cmp++;
    if (GNT_REF !== 1'b1) begin
      n_bad++; $display("FAIL rst_first_ref: got %b want 1", GNT_REF);
    end
  endtask

  initial begin
    test_reset();
    test_init_hold();
    test_single_cpu();
    test_urgent_priority();
    test_tick_with_grant();
    test_overflow();
    test_reset_mid_ref();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
